// File: rtl/search_dispatcher.sv
`default_nettype none
// search_dispatcher: steps candidate states S, S+step, S+2*step ... through the
// alpha-beta tester and returns each (candidate, result, timeout) on a valid/ready port.
module search_dispatcher #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [127:0]     seed_S,
  input  logic [31:0]      seed_L,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      step,
  output logic [127:0]     t_S,
  output logic [31:0]      t_L,
  output logic             t_rst,
  input  logic             t_finish,
  input  logic [127:0]     t_outS,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_idx,
  output logic [127:0]     res_cand,
  output logic [127:0]     res_S,
  output logic             res_timeout,
  output logic             busy,
  output logic             done
);

  localparam int LCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_EMIT = 3'd3,
    S_NEXT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       ts_q, ts_d;
  logic [31:0]        tl_q, tl_d;
  logic [31:0]        step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [127:0]       rs_q, rs_d;
  logic               rto_q, rto_d;
  logic               fin_q, fin_d;
  logic               prev_q, prev_d;
  logic               done_q, done_d;
  logic               fin_edge;

  // prev is forced high outside RUN so a finish left high from LOAD cannot count as an edge
  assign fin_edge = fin_q & ~prev_q;

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    tl_d    = tl_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lcnt_d  = lcnt_q;
    wcnt_d  = wcnt_q;
    rs_d    = rs_q;
    rto_d   = rto_q;
    done_d  = 1'b0;
    fin_d   = t_finish;
    prev_d  = (state_q == S_RUN) ? fin_q : 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            ts_d    = seed_S;
            tl_d    = seed_L;
            step_d  = step;
            cnt_d   = count;
            idx_d   = '0;
            lcnt_d  = '0;
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (lcnt_q == LCNT_W'(RST_CYCLES - 1)) begin
          wcnt_d  = '0;
          state_d = S_RUN;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end
      S_RUN: begin
        if (fin_edge) begin
          rs_d    = t_outS;
          rto_d   = 1'b0;
          state_d = S_EMIT;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          rs_d    = '0;
          rto_d   = 1'b1;
          state_d = S_EMIT;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          if (idx_q == cnt_q - CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        ts_d    = ts_q + {96'd0, step_q};
        idx_d   = idx_q + CNT_W'(1);
        lcnt_d  = '0;
        state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ts_q    <= '0;
      tl_q    <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      lcnt_q  <= '0;
      wcnt_q  <= '0;
      rs_q    <= '0;
      rto_q   <= 1'b0;
      fin_q   <= 1'b0;
      prev_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      tl_q    <= tl_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lcnt_q  <= lcnt_d;
      wcnt_q  <= wcnt_d;
      rs_q    <= rs_d;
      rto_q   <= rto_d;
      fin_q   <= fin_d;
      prev_q  <= prev_d;
      done_q  <= done_d;
    end
  end

  assign t_S         = ts_q;
  assign t_L         = tl_q;
  assign t_rst       = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_NEXT);
  assign res_valid   = (state_q == S_EMIT);
  assign res_idx     = idx_q;
  assign res_cand    = ts_q;
  assign res_S       = rs_q;
  assign res_timeout = rto_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule
`default_nettype wire
